// File: rtl/multicycle_alu.sv
// ============================================================================
// Module  : multicycle_alu
// Brief   : Valid/ready ALU with bit-serial shifts and an optional shift-add
//           multiplier / restoring divider (macro MULTICYCLE_ALU_MULDIV_EN).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [4:0]         ALUControlOp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Output
);

  localparam logic [4:0] c_op_add  = 5'b00000;
  localparam logic [4:0] c_op_sub  = 5'b00001;
  localparam logic [4:0] c_op_sll  = 5'b00010;
  localparam logic [4:0] c_op_slt  = 5'b00011;
  localparam logic [4:0] c_op_sltu = 5'b00100;
  localparam logic [4:0] c_op_xor  = 5'b00101;
  localparam logic [4:0] c_op_srl  = 5'b00110;
  localparam logic [4:0] c_op_sra  = 5'b00111;
  localparam logic [4:0] c_op_or   = 5'b01000;
  localparam logic [4:0] c_op_and  = 5'b01001;
  localparam logic [4:0] c_op_jalr = 5'b01010;

`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam logic [4:0] c_op_mul   = 5'b01011;
  localparam logic [4:0] c_op_mulhu = 5'b01100;
  localparam logic [4:0] c_op_divu  = 5'b01101;
  localparam logic [4:0] c_op_remu  = 5'b01110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_MUL   = 3'd2,
    ST_DIV   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_DONE  = 3'd4
  } state_t;
`endif

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [4:0]         r_op;
  logic [SHAMT_W:0]   r_cnt;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_result;
  logic [WIDTH-1:0]   w_shift_next;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;

  assign w_sum      = A + B;
  assign w_shamt    = B[SHAMT_W-1:0];
  assign w_is_shift = (ALUControlOp == c_op_sll) || (ALUControlOp == c_op_srl) ||
                      (ALUControlOp == c_op_sra);

  // Shifts resolve here only for a zero shift amount, which passes A through.
  always_comb begin
    w_result = '0;
    case (ALUControlOp)
      c_op_add:  w_result = w_sum;
      c_op_sub:  w_result = A - B;
      c_op_slt:  w_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      c_op_sltu: w_result = {{(WIDTH-1){1'b0}}, (A < B)};
      c_op_xor:  w_result = A ^ B;
      c_op_or:   w_result = A | B;
      c_op_and:  w_result = A & B;
      c_op_jalr: w_result = {w_sum[WIDTH-1:1], 1'b0};
      c_op_sll, c_op_srl, c_op_sra: w_result = A;
      default:   w_result = '0;
    endcase
  end

  always_comb begin
    w_shift_next = r_a >> 1;
    case (r_op)
      c_op_sll: w_shift_next = r_a << 1;
      c_op_sra: w_shift_next = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
      default:  w_shift_next = r_a >> 1;
    endcase
  end

`ifdef MULTICYCLE_ALU_MULDIV_EN
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shifted;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic               w_is_mul;
  logic               w_is_div;

  assign w_is_mul = (ALUControlOp == c_op_mul) || (ALUControlOp == c_op_mulhu);
  assign w_is_div = (ALUControlOp == c_op_divu) || (ALUControlOp == c_op_remu);

  // r_prod = {partial high product, remaining multiplier bits}; shifts right.
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                     (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

  // A zero divisor always "fits", giving all-ones quotient and remainder = A.
  assign w_div_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_div_ge      = (w_div_shifted >= {1'b0, r_a});
  assign w_div_diff    = w_div_shifted[WIDTH-1:0] - r_a;
  assign w_rem_next    = w_div_ge ? w_div_diff : w_div_shifted[WIDTH-1:0];
  assign w_quo_next    = {r_quo[WIDTH-2:0], w_div_ge};
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Output    <= '0;
      r_a       <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
`ifdef MULTICYCLE_ALU_MULDIV_EN
      r_prod    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op     <= ALUControlOp;
            in_ready <= 1'b0;
            if (w_is_shift && (w_shamt != '0)) begin
              r_a     <= A;
              r_cnt   <= {1'b0, w_shamt};
              r_state <= ST_SHIFT;
            end
`ifdef MULTICYCLE_ALU_MULDIV_EN
            else if (w_is_mul) begin
              r_a     <= A;
              r_prod  <= {{WIDTH{1'b0}}, B};
              r_cnt   <= (SHAMT_W+1)'(WIDTH);
              r_state <= ST_MUL;
            end else if (w_is_div) begin
              r_a     <= B;
              r_quo   <= A;
              r_rem   <= '0;
              r_cnt   <= (SHAMT_W+1)'(WIDTH);
              r_state <= ST_DIV;
            end
`endif
            else begin
              Output    <= w_result;
              out_valid <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          r_a   <= w_shift_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == (SHAMT_W+1)'(1)) begin
            Output    <= w_shift_next;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
`ifdef MULTICYCLE_ALU_MULDIV_EN
        ST_MUL: begin
          r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == (SHAMT_W+1)'(1)) begin
            Output    <= (r_op == c_op_mulhu) ? w_mul_sum[WIDTH:1]
                                              : {w_mul_sum[0], r_prod[WIDTH-1:1]};
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == (SHAMT_W+1)'(1)) begin
            Output    <= (r_op == c_op_divu) ? w_quo_next : w_rem_next;
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// ============================================================================
// Module  : tb_multicycle_alu
// Brief   : Self-checking bench for multicycle_alu (WIDTH=32); honours
//           MULTICYCLE_ALU_MULDIV_EN when the build defines it.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [4:0]  op_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .CLK          (clk),
    .RST          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (a_in),
    .B            (b_in),
    .ALUControlOp (op_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .Output       (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the opcode definitions.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    int unsigned n;
    logic [63:0] p;
    n = b % 32;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << n;
      5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> n;
      5'd7:  return 32'($signed(a) >>> n);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return (a + b) & 32'hFFFF_FFFE;
`ifdef MULTICYCLE_ALU_MULDIV_EN
      5'd11: return p[31:0];
      5'd12: return p[63:32];
      5'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd14: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] op, input logic [31:0] b);
    if (op == 5'd2 || op == 5'd6 || op == 5'd7) return int'(b % 32) + 1;
`ifdef MULTICYCLE_ALU_MULDIV_EN
    if (op >= 5'd11 && op <= 5'd14) return 33;
`endif
    return 1;
  endfunction

  // Issue one request, measure latency, apply 'hold' cycles of backpressure, retire.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat;
    logic [31:0] exp;
    exp = model(op, a, b);
    lat = 0;
    while (!in_ready && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_inrdy"}, in_ready, 1);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    op_in = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    op_in = 5'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, "_lat"}, lat, exp_lat(op, b));
    check({tag, "_out"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_v"}, {out_valid, in_ready}, 2'b10);
      check({tag, "_hold_o"}, result, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ret"}, {in_ready, out_valid}, 2'b10);
    check({tag, "_keep"}, result, exp);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    #12;
    check("rst_state", {in_ready, out_valid}, 2'b10);
    check("rst_out", result, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("slt_ovf", 5'd3, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sra4", 5'd7, 32'h8000_0000, 32'd4, 0);
    run_op("srl4", 5'd6, 32'h8000_0000, 32'd4, 0);
    run_op("sll0", 5'd2, 32'd1, 32'd0, 0);
    run_op("sll31", 5'd2, 32'd1, 32'd31, 1);
    run_op("bp_add", 5'd0, 32'd3, 32'd4, 5);
    run_op("sltu", 5'd4, 32'd1, 32'hFFFF_FFFF, 0);
    run_op("slt_neg", 5'd3, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("jalr", 5'd10, 32'h1000_0003, 32'd4, 0);
    run_op("undef", 5'd31, 32'd6, 32'd7, 0);
    run_op("op0b", 5'd11, 32'd6, 32'd7, 0);
`ifdef MULTICYCLE_ALU_MULDIV_EN
    run_op("mul", 5'd11, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("mulhu", 5'd12, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("divu", 5'd13, 32'd100, 32'd7, 0);
    run_op("remu", 5'd14, 32'd100, 32'd7, 0);
    run_op("div0", 5'd13, 32'd5, 32'd0, 0);
    run_op("rem0", 5'd14, 32'd5, 32'd0, 0);
`endif

    // Asynchronous reset in the middle of a long shift.
    in_valid = 1'b1;
    a_in = 32'hDEAD_BEEF;
    b_in = 32'd20;
    op_in = 5'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_state", {in_ready, out_valid}, 2'b10);
    check("rst_mid_out", result, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("xor_after_rst", 5'd5, 32'h0000_F0F0, 32'h0000_FFFF, 0);

    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1, 31'($urandom)};
      run_op("rnd", op, a, b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHAMT_W, default 5, shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  operation request valid.
REQ-006 SHALL have port in_ready  out  1  block can accept a request.
REQ-007 SHALL have port A  in  WIDTH  operand A.
REQ-008 SHALL have port B  in  WIDTH  operand B; B[SHAMT_W-1:0] is the shift amount for shifts.
REQ-009 SHALL have port ALUControlOp  in  5  operation code.
REQ-010 SHALL have port out_valid  out  1  Output holds a completed result.
REQ-011 SHALL have port out_ready  in  1  consumer takes the result.
REQ-012 SHALL have port Output  out  WIDTH  registered result.

Function
REQ-013 Opcodes: ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001, JALR 01010 (A+B with bit 0 cleared).
REQ-014 FSM states: IDLE, SHIFT, MUL, DIV, DONE; in_ready = (state==IDLE).
REQ-015 A request is accepted on a rising edge with in_valid && in_ready; operands and op are captured at that edge and are ignored afterwards.
REQ-016 Single-cycle ops (ADD, SUB, SLT, SLTU, XOR, OR, AND, JALR): IDLE->DONE; out_valid rises 1 cycle after acceptance.
REQ-017 Shifts: IDLE->SHIFT, shifting 1 bit per cycle; with shamt n, out_valid rises n+1 cycles after acceptance; n=0 gives Output=A after 1 cycle.
REQ-018 SRA SHALL replicate A[WIDTH-1]; SRL and SLL SHALL shift in zeros.
REQ-019 SLT compares signed and SLTU unsigned; result is 1 or 0, zero-extended to WIDTH.
REQ-020 Arithmetic wraps modulo 2^WIDTH; no carry or overflow output.
REQ-021 Undefined opcodes complete as single-cycle ops with Output=0.
REQ-022 DONE: out_valid=1 and Output is held stable until an edge with out_ready=1, then the FSM returns to IDLE; a new request is not accepted in that same cycle.
REQ-023 out_valid=0 and Output holds its last value in every state except DONE.

Reset
REQ-024 RST asserted, at any time including mid-operation, SHALL immediately force state=IDLE, in_ready=1, out_valid=0, Output=0, and clear all counters and partial results.
REQ-025 The first request may be accepted on the first rising edge after RST deasserts.

Configuration
REQ-026 Macro MULTICYCLE_ALU_MULDIV_EN, when defined, adds opcodes MUL 01011 (low WIDTH bits, shift-add), MULHU 01100 (high WIDTH bits, unsigned), DIVU 01101 and REMU 01110 (unsigned restoring division).
REQ-027 With the macro defined, MUL/MULHU use the MUL state and DIVU/REMU use the DIV state; each takes exactly WIDTH cycles, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-028 With the macro defined and divisor 0: DIVU returns all ones and REMU returns A.
REQ-029 With the macro undefined, opcodes 01011-01110 SHALL be treated as undefined (REQ-021), and no MUL or DIV state logic is present.

Verification
REQ-030 WIDTH=32, ADD A=0x7FFFFFFF B=1 -> out_valid 1 cycle after accept, Output=0x80000000; SLT on the same operands -> 0.
REQ-031 SRA A=0x80000000 B=4 -> Output=0xF8000000 after 5 cycles; SRL on the same operands -> 0x08000000; SLL A=1 B=0 -> 0x00000001 after 1 cycle.
REQ-032 Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> Output=7 and out_valid held, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
REQ-033 RST pulsed 3 cycles into SRL by 20 -> out_valid=0, Output=0, in_ready=1 immediately; a following XOR 0xF0F0 ^ 0xFFFF -> 0x0F0F.
REQ-034 Macro defined: MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE after 33 cycles; MULHU on the same operands -> 1; DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF.
REQ-035 Macro undefined: op 01011 with A=6 B=7 -> Output=0 after 1 cycle.
